instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks a word-aligned fetch PC through
// instruction memory into a 2-entry {pc, instr} FIFO feeding decode.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      leave IDLE and fetch from RESET_PC
//   imem_addr / imem_instr     combinational instruction memory port
//   redirect_valid/_pc         flush FIFO and refetch from redirect_pc
//   out_valid/_ready/_instr/_pc head-of-FIFO handshake to decode
//   fault, state               fault flag and 00 IDLE / 01 RUN / 10 FAULT
module instr_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fault,
   output logic [1:0]  state
);

   localparam logic [1:0]  S_IDLE  = 2'b00;
   localparam logic [1:0]  S_RUN   = 2'b01;
   localparam logic [1:0]  S_FAULT = 2'b10;
   localparam logic [31:0] WORDS   = 32'(MEM_WORDS);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  cnt_q, cnt_d;
   // slot 0 is always the head, so it keeps the last shown entry once empty
   logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
   logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;

   logic legal, flush, pop, room, push;

   // range test on the word index, done before any +4 wrap
   assign legal = (pc_q[1:0] == 2'b00) &&
                  ({2'b00, pc_q[31:2]} < WORDS);
   assign flush = redirect_valid && (state_q != S_IDLE);
   assign pop   = out_valid && out_ready && !flush;
   assign room  = (cnt_q != 2'd2) || pop;
   assign push  = (state_q == S_RUN) && !flush && legal && room;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               pc_d    = RESET_PC;
            end
         end
         S_RUN: begin
            if (flush) begin
               pc_d = redirect_pc;
            end else if (push) begin
               pc_d = pc_q + 32'd4;
            end else if (!legal && room) begin
               state_d = S_FAULT;
            end
         end
         S_FAULT: begin
            if (flush) begin
               state_d = S_RUN;
               pc_d    = redirect_pc;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      pc0_d  = pc0_q;
      ins0_d = ins0_q;
      pc1_d  = pc1_q;
      ins1_d = ins1_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else if (push && pop) begin
         if (cnt_q == 2'd2) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = pc_q;
            ins1_d = imem_instr;
         end else begin
            pc0_d  = pc_q;
            ins0_d = imem_instr;
         end
      end else if (push) begin
         cnt_d = cnt_q + 2'd1;
         if (cnt_q == 2'd0) begin
            pc0_d  = pc_q;
            ins0_d = imem_instr;
         end else begin
            pc1_d  = pc_q;
            ins1_d = imem_instr;
         end
      end else if (pop) begin
         cnt_d = cnt_q - 2'd1;
         if (cnt_q == 2'd2) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= 2'd0;
         pc0_q   <= 32'd0;
         ins0_q  <= 32'd0;
         pc1_q   <= 32'd0;
         ins1_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         pc0_q   <= pc0_d;
         ins0_q  <= ins0_d;
         pc1_q   <= pc1_d;
         ins1_q  <= ins1_d;
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = (cnt_q != 2'd0);
   assign out_pc    = pc0_q;
   assign out_instr = ins0_q;
   assign fault     = (state_q == S_FAULT);
   assign state     = state_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed stimulus queues the
// expected {pc, instr} stream; a negedge monitor checks each handshake.
module tb_instr_fetch_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;
   logic [1:0]  state;

   logic [31:0] mem [64];
   ent_t        sb [$];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   assign imem_instr = (imem_addr[31:8] == 24'd0) ?
                       mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

   instr_fetch_ctrl #(
      .RESET_PC  (32'h0000_0000),
      .MEM_WORDS (64)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fault          (fault),
      .state          (state)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input int idx);
      ent_t e;
      e.pc  = 32'(idx) << 2;
      e.ins = mem[idx];
      sb.push_back(e);
   endtask

   // monitor: a handshake is seen just before the edge that pops it
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_entry actual_pc=%h expected=none",
                     out_pc);
         end else begin
            ent_t e;
            e = sb.pop_front();
            chk("sb_pc", out_pc, e.pc);
            chk("sb_instr", out_instr, e.ins);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++)
         mem[i] = 32'h1300_0000 + 32'(i) * 32'h0000_0101;

      // asynchronous reset values before any edge
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("idle_hold", 32'(state), 32'd0);

      // redirect ignored in IDLE
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      chk("idle_redir_state", 32'(state), 32'd0);
      chk("idle_redir_addr", imem_addr, 32'h0);

      // sequential fetch with decode always ready
      for (int i = 0; i < 4; i++) expect_word(i);
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      chk("start_state", 32'(state), 32'd1);
      chk("start_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("seq_valid", 32'(out_valid), 32'd1);
         chk("seq_pc", out_pc, 32'(i) << 2);
         chk("seq_instr", out_instr, mem[i]);
      end
      step();
      out_ready = 1'b0;
      start     = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("stall_addr", imem_addr, 32'h18);
      chk("stall_head", out_pc, 32'h10);
      chk("start_ignored", 32'(state), 32'd1);
      chk("seq_drained", 32'(sb.size()), 32'd0);

      // redirect with two entries buffered
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      chk("redir_flush", 32'(out_valid), 32'd0);
      chk("redir_addr", imem_addr, 32'h40);
      expect_word(16);
      out_ready = 1'b1;
      step();
      chk("redir_valid", 32'(out_valid), 32'd1);
      chk("redir_pc", out_pc, 32'h40);
      chk("redir_instr", out_instr, mem[16]);
      step();
      out_ready = 1'b0;
      step();
      step();
      chk("redir_drained", 32'(sb.size()), 32'd0);

      // asynchronous reset mid-RUN with a full FIFO
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_addr", imem_addr, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("arst_idle", 32'(state), 32'd0);

      // backpressure then run off the end of memory
      for (int i = 0; i < 64; i++) expect_word(i);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("bp_addr", imem_addr, 32'h8);
      chk("bp_head", out_pc, 32'h0);
      out_ready = 1'b1;
      for (int n = 0; n < 200 && state != 2'b10; n++) step();
      chk("oor_state", 32'(state), 32'd2);
      chk("oor_fault", 32'(fault), 32'd1);
      chk("oor_addr", imem_addr, 32'h100);
      step();
      step();
      step();
      chk("oor_drain", 32'(out_valid), 32'd0);
      chk("oor_sticky", 32'(fault), 32'd1);
      chk("oor_all", 32'(sb.size()), 32'd0);

      // recover from FAULT
      out_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      step();
      redirect_valid = 1'b0;
      chk("rec_fault", 32'(fault), 32'd0);
      chk("rec_state", 32'(state), 32'd1);
      chk("rec_valid", 32'(out_valid), 32'd0);
      expect_word(0);
      step();
      chk("rec_pc", out_pc, 32'h0);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // misaligned redirect target
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2;
      step();
      redirect_valid = 1'b0;
      chk("mis_state_run", 32'(state), 32'd1);
      chk("mis_addr", imem_addr, 32'h2);
      step();
      chk("mis_state", 32'(state), 32'd2);
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_valid", 32'(out_valid), 32'd0);
      chk("final_sb", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
